ctrl_tile_sequencer: RTL and testbench
======================================

Name: ctrl_tile_sequencer

Overview:
Parametrised controller for the N×N vector/systolic multiplier array. It sequences one or more back-to-back tiles. Each tile is a feed phase (N cycles) followed by a drain phase (PIPE_LAT+1 cycles). It exposes a per-cycle step counter, phase, and enable strobes to the datapath, and supports stall, abort and restart. It sits between the top-level command interface and the array/accumulator datapath.

Parameters:
N, 16, matrix dimension; number of feed cycles per tile.
PIPE_LAT, 2, array pipeline latency; the drain phase lasts PIPE_LAT+1 cycles.
CNT_W, 6, state_count width. Legal only if N+PIPE_LAT < 2^CNT_W-1.
TILE_W, 8, width of the tile-count and tile-index fields.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous reset, active-low
start  in  1  start request; sampled only in IDLE or DONE
num_tiles  in  TILE_W  tiles per job; latched on accepted start; 0 is treated as 1
stall  in  1  freezes the sequencer while RUN
abort  in  1  cancels the job while RUN
state_count  out  CNT_W  step within the current tile
tile_idx  out  TILE_W  index of the current tile
phase  out  2  00 IDLE, 01 RUN, 10 DONE
busy  out  1  high in RUN
feed_en  out  1  array input strobe
drain_en  out  1  array drain strobe
tile_done  out  1  one-cycle pulse per completed tile
end_signal  out  1  job complete; level signal
aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rstn=0) forces:
  - phase=IDLE, state_count=0, tile_idx=0, busy=0
  - tile_done=0, end_signal=0, aborted=0
  - latched tile count=1
  - No clock is required for reset to take effect. Deassertion is synchronous to clk.
- All outputs are registered except feed_en and drain_en, which are combinational from registered state and stall:
  - feed_en = RUN & !stall & state_count<N
  - drain_en = RUN & !stall & state_count>=N
- Define LAST = N+PIPE_LAT.
- IDLE:
  - start=1 at a clock edge → next cycle: phase=RUN, busy=1, state_count=0, tile_idx=0, end_signal=0.
  - num_tiles is latched at the same edge.
- RUN, with stall=0 and abort=0:
  - state_count<LAST: state_count increments by 1.
  - state_count==LAST and tile_idx<tiles-1: state_count←0, tile_idx←tile_idx+1, tile_done←1.
  - state_count==LAST and tile_idx==tiles-1: phase←DONE, busy←0, state_count←all ones, end_signal←1, tile_done←1. tile_idx holds its final value.
  - Each tile therefore takes LAST+1 cycles. tile_done is high for exactly the one cycle after each tile's LAST cycle.
- RUN with stall=1: every register holds its value, and feed_en=drain_en=0.
- RUN with abort=1:
  - Abort has priority over stall and over tile completion.
  - Next cycle: phase=IDLE, busy=0, state_count=0, tile_idx=0, aborted=1 for one cycle, tile_done=0, end_signal stays 0.
- start while RUN is ignored. abort or stall outside RUN is ignored.
- DONE:
  - state_count=all ones and end_signal=1, held until the next start.
  - start in DONE behaves exactly as start in IDLE: it clears end_signal and begins a new job on the following cycle.
- Reset asserted mid-job returns immediately to the reset state. No tile_done or aborted pulse is generated.

Test Plan:
1. N=16, PIPE_LAT=2, num_tiles=1, start pulse at edge k:
   - state_count 0..18 on cycles k+1..k+19.
   - feed_en high for 16 cycles, drain_en high for 3 cycles.
   - Cycle k+20: state_count=63, end_signal=1, tile_done=1, phase=10.
2. num_tiles=3:
   - 57 RUN cycles.
   - tile_done pulses after the cycles where state_count=18 with tile_idx=0, 1 and 2.
   - end_signal rises once; final tile_idx=2.
3. stall=1 for 5 cycles while state_count=7:
   - state_count holds at 7, feed_en=0.
   - Total job length grows by exactly 5 cycles.
4. abort=1 while state_count=10 and tile_idx=1, with stall=1 in the same cycle:
   - Next cycle: phase=IDLE, state_count=0, aborted=1 for one cycle, end_signal=0.
5. num_tiles=0 → behaves as a single tile (scenario 1). A start asserted during RUN has no effect.
6. Back-to-back jobs:
   - start in DONE → end_signal clears next cycle and state_count restarts at 0.
   - rstn=0 mid-tile → all outputs reach reset values immediately, without a clock edge.

Source files
------------

// File: rtl/ctrl_tile_sequencer.sv
// Tile sequencer for the NxN array: N feed cycles then PIPE_LAT+1 drain cycles per tile, repeated for each tile.
// Outputs are registered (one-cycle latency) except feed_en/drain_en; stall freezes RUN; abort wins over stall.
module ctrl_tile_sequencer #(
    parameter int N        = 16,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 6,
    parameter int TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    input  logic              abort,
    output logic [CNT_W-1:0]  state_count,
    output logic [TILE_W-1:0] tile_idx,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              feed_en,
    output logic              drain_en,
    output logic              tile_done,
    output logic              end_signal,
    output logic              aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(N + PIPE_LAT);
    localparam logic [CNT_W-1:0]  C_N    = CNT_W'(N);
    localparam logic [TILE_W-1:0] C_ONE  = TILE_W'(1);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [TILE_W-1:0]  r_tile_idx, w_tile_idx;
    logic [TILE_W-1:0]  r_tiles, w_tiles;
    logic               r_busy, w_busy;
    logic               r_tile_done, w_tile_done;
    logic               r_end, w_end;
    logic               r_aborted, w_aborted;
    logic               w_last_tile;

    assign w_last_tile = (r_tile_idx == (r_tiles - C_ONE));

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_tile_idx  = r_tile_idx;
        w_tiles     = r_tiles;
        w_end       = r_end;
        w_tile_done = 1'b0;
        w_aborted   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state    = S_RUN;
                    w_cnt      = '0;
                    w_tile_idx = '0;
                    w_end      = 1'b0;
                    // A zero tile count would otherwise never terminate.
                    w_tiles    = (num_tiles == '0) ? C_ONE : num_tiles;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state    = S_IDLE;
                    w_cnt      = '0;
                    w_tile_idx = '0;
                    w_end      = 1'b0;
                    w_aborted  = 1'b1;
                end else if (!stall) begin
                    if (r_cnt != C_LAST) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end else if (!w_last_tile) begin
                        w_cnt       = '0;
                        w_tile_idx  = r_tile_idx + C_ONE;
                        w_tile_done = 1'b1;
                    end else begin
                        w_state     = S_DONE;
                        w_cnt       = '1;
                        w_end       = 1'b1;
                        w_tile_done = 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
        w_busy = (w_state == S_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tile_idx  <= '0;
            r_tiles     <= C_ONE;
            r_busy      <= 1'b0;
            r_tile_done <= 1'b0;
            r_end       <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_tile_idx  <= w_tile_idx;
            r_tiles     <= w_tiles;
            r_busy      <= w_busy;
            r_tile_done <= w_tile_done;
            r_end       <= w_end;
            r_aborted   <= w_aborted;
        end
    end

    assign state_count = r_cnt;
    assign tile_idx    = r_tile_idx;
    assign phase       = r_state;
    assign busy        = r_busy;
    assign tile_done   = r_tile_done;
    assign end_signal  = r_end;
    assign aborted     = r_aborted;
    assign feed_en     = (r_state == S_RUN) && !stall && (r_cnt < C_N);
    assign drain_en    = (r_state == S_RUN) && !stall && (r_cnt >= C_N);

endmodule

// File: tb/tb_ctrl_tile_sequencer.sv
// Bench for ctrl_tile_sequencer: directed scenarios with literal expectations plus random traffic against a job-level model.
module tb_ctrl_tile_sequencer;
    localparam int N    = 16;
    localparam int PL   = 2;
    localparam int CW   = 6;
    localparam int TW   = 8;
    localparam int P    = N + PL + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] num_tiles = '0;
    logic [CW-1:0] state_count;
    logic [TW-1:0] tile_idx;
    logic [1:0]    phase;
    logic          busy, feed_en, drain_en, tile_done, end_signal, aborted;

    ctrl_tile_sequencer #(.N(N), .PIPE_LAT(PL), .CNT_W(CW), .TILE_W(TW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles),
        .stall(stall), .abort(abort), .state_count(state_count),
        .tile_idx(tile_idx), .phase(phase), .busy(busy), .feed_en(feed_en),
        .drain_en(drain_en), .tile_done(tile_done), .end_signal(end_signal),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level model: a job is tiles*P un-stalled RUN cycles; position within it gives step and tile.
    int m_phase = 0;
    int m_active = 0;
    int m_tiles = 1;
    bit m_end = 0, m_td = 0, m_ab = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0; m_active = 0; m_tiles = 1; m_end = 0; m_td = 0; m_ab = 0;
        end else begin
            m_td = 0;
            m_ab = 0;
            if (m_phase != 1) begin
                if (start) begin
                    m_phase  = 1;
                    m_active = 0;
                    m_tiles  = (num_tiles == 0) ? 1 : int'(num_tiles);
                    m_end    = 0;
                end
            end else if (abort) begin
                m_phase = 0; m_active = 0; m_ab = 1; m_end = 0;
            end else if (!stall) begin
                m_active++;
                if (m_active % P == 0) m_td = 1;
                if (m_active == m_tiles * P) begin
                    m_phase = 2;
                    m_end   = 1;
                end
            end
        end
    end

    function automatic logic [21:0] model_vec();
        int step, idx;
        bit fe, de;
        step = 0; idx = 0;
        if (m_phase == 1) begin
            step = m_active % P;
            idx  = m_active / P;
        end else if (m_phase == 2) begin
            step = (1 << CW) - 1;
            idx  = m_tiles - 1;
        end
        fe = (m_phase == 1) && !stall && (step < N);
        de = (m_phase == 1) && !stall && (step >= N);
        return {2'(m_phase), 6'(step), 8'(idx), (m_phase == 1), fe, de, m_td, m_end, m_ab};
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_vec", {10'd0, phase, state_count, tile_idx, busy, feed_en, drain_en,
                              tile_done, end_signal, aborted}, {10'd0, model_vec()});
    end

    task automatic start_job(input logic [TW-1:0] nt);
        start = 1'b1;
        num_tiles = nt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs from the first RUN cycle until the job leaves RUN; optionally stalls 5 cycles at a step
    // and pokes start mid-job.
    task automatic run_job(input int stall_at, input bit poke, output int runs, output int feeds,
                           output int drains, output int tds, output int ends);
        int sl;
        bit done_ok;
        sl = 5; done_ok = 0;
        runs = 0; feeds = 0; drains = 0; tds = 0; ends = 0;
        for (int i = 0; i < 1000; i++) begin
            stall = (stall_at >= 0) && (int'(state_count) == stall_at) && (sl > 0);
            if (stall) sl--;
            start = poke && (state_count == 6'd5);
            #1;
            if (phase != 2'b01) begin
                tds += int'(tile_done);
                done_ok = 1;
                break;
            end
            runs++;
            feeds  += int'(feed_en);
            drains += int'(drain_en);
            tds    += int'(tile_done);
            ends   += int'(end_signal);
            if (stall) begin
                chk("stall_feed_en", 32'(feed_en), 0);
                chk("stall_hold_cnt", 32'(state_count), 32'(stall_at));
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!done_ok) chk("job_timeout", 1, 0);
    endtask

    int runs, feeds, drains, tds, ends;

    initial begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_cnt", 32'(state_count), 0);
        chk("rst_idx", 32'(tile_idx), 0);
        chk("rst_flags", {26'd0, busy, tile_done, end_signal, aborted, feed_en, drain_en}, 0);
        chk_en = 1'b1;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single tile
        start_job(8'd1);
        run_job(-1, 0, runs, feeds, drains, tds, ends);
        chk("s1_runs", 32'(runs), 19);
        chk("s1_feeds", 32'(feeds), 16);
        chk("s1_drains", 32'(drains), 3);
        chk("s1_done_vec", {24'd0, phase, state_count}, {24'd0, 2'b10, 6'd63});
        chk("s1_end_td", {30'd0, end_signal, tile_done}, 3);
        @(posedge clk); #1;

        // Three tiles, started from DONE
        start_job(8'd3);
        run_job(-1, 0, runs, feeds, drains, tds, ends);
        chk("s2_runs", 32'(runs), 57);
        chk("s2_tds", 32'(tds), 3);
        chk("s2_end_low_in_run", 32'(ends), 0);
        chk("s2_final_idx", 32'(tile_idx), 2);
        chk("s2_end", 32'(end_signal), 1);
        @(posedge clk); #1;

        // Stall for 5 cycles at step 7
        start_job(8'd1);
        run_job(7, 0, runs, feeds, drains, tds, ends);
        chk("s3_runs", 32'(runs), 24);
        chk("s3_feeds", 32'(feeds), 16);

        // Abort with concurrent stall at tile 1 step 10
        start_job(8'd3);
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 200; i++) begin
                if (tile_idx == 8'd1 && state_count == 6'd10) begin
                    found = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!found) chk("s4_reach_timeout", 1, 0);
        end
        abort = 1'b1;
        stall = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        stall = 1'b0;
        chk("s4_phase", 32'(phase), 0);
        chk("s4_cnt", 32'(state_count), 0);
        chk("s4_idx", 32'(tile_idx), 0);
        chk("s4_pulses", {29'd0, aborted, end_signal, tile_done}, 4);
        @(posedge clk); #1;
        chk("s4_abort_one_cycle", 32'(aborted), 0);

        // Zero tiles acts as one; start during RUN ignored
        start_job(8'd0);
        run_job(-1, 1, runs, feeds, drains, tds, ends);
        chk("s5_runs", 32'(runs), 19);
        chk("s5_tds", 32'(tds), 1);
        @(posedge clk); #1;

        // Restart from DONE, then asynchronous reset mid-tile
        start_job(8'd2);
        chk("s6_restart", {23'd0, end_signal, phase, state_count}, {23'd0, 1'b0, 2'b01, 6'd0});
        repeat (8) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("s6_rst_vec", {16'd0, phase, state_count, tile_idx},
            {16'd0, 2'b00, 6'd0, 8'd0});
        chk("s6_rst_flags", {26'd0, busy, tile_done, end_signal, aborted, feed_en, drain_en}, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Random traffic, checked every cycle by the compare process
        repeat (4000) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 7) == 0);
            num_tiles = TW'($urandom_range(0, 3));
            stall     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 60) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; stall = 1'b0; abort = 1'b0;
        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
